// File: rtl/max_unpool2d_pkg.sv
// max_unpool2d_pkg: state, row-buffer entry and index-width helper for max_unpool2d
package max_unpool2d_pkg;
  localparam int VAL_MAX_W = 32;
  localparam int IDX_MAX_W = 8;
  typedef enum logic {FILL, EMIT} state_e;
  typedef struct packed {
    logic [VAL_MAX_W-1:0] value;
    logic [IDX_MAX_W-1:0] index;
  } entry_t;
  function automatic int idx_width(input int kw, input int kh);
    return $clog2(kw * kh) > 1 ? $clog2(kw * kh) : 1;
  endfunction
endpackage

// File: rtl/unpool_row_buffer.sv
// unpool_row_buffer: one pooled row of {value, index}, registered write, combinational read
module unpool_row_buffer import max_unpool2d_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output entry_t        rdata_o
);
  entry_t mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/max_unpool2d.sv
// max_unpool2d: streaming 2D max-unpooling, one pooled row in, KERNEL_HEIGHT full-res rows out.
// MAX_UNPOOL2D_IDX_CHECK_EN adds a sticky idx_err flag for out-of-range argmax indices.
module max_unpool2d import max_unpool2d_pkg::*; #(
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int DATA_IN_0_PRECISION_1 = 3,
  parameter int DATA_IN_0_WIDTH = 2,
  parameter int DATA_IN_0_HEIGHT = 2,
  parameter int KERNEL_WIDTH = 2,
  parameter int KERNEL_HEIGHT = 2,
  parameter int DATA_OUT_0_PRECISION_0 = 8,
  parameter int DATA_OUT_0_PRECISION_1 = 3,
  localparam int IDX_WIDTH = idx_width(KERNEL_WIDTH, KERNEL_HEIGHT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic [IDX_WIDTH-1:0]              data_in_1,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
`ifdef MAX_UNPOOL2D_IDX_CHECK_EN
  ,
  output logic                              idx_err
`endif
);
  localparam int W = DATA_IN_0_WIDTH;
  localparam int KW = KERNEL_WIDTH;
  localparam int KH = KERNEL_HEIGHT;
  localparam int DW = DATA_OUT_0_PRECISION_0;
  localparam int CW = $clog2(W) + 1;
  localparam int NW = $clog2(KW) + 1;
  localparam int MW = $clog2(KH) + 1;
  localparam int RW = $clog2(DATA_IN_0_HEIGHT) + 1;
  localparam int AW = W > 1 ? $clog2(W) : 1;

  if (DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0) $error("value widths differ");
  if (DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) $error("fractional widths differ");
  if (DATA_IN_0_PRECISION_0 > VAL_MAX_W || IDX_WIDTH > IDX_MAX_W) $error("entry field too narrow");

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, j_q, j_d;
  logic [NW-1:0]   n_q, n_d;
  logic [MW-1:0]   m_q, m_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   out_q, out_d;
  logic            vld_q, vld_d;
  logic            acc, ohs, last_n, last_j, last_m, load, step, done;
  entry_t          wentry, rd_buf, rd;
  logic            unused_val;

  unpool_row_buffer #(.DEPTH(W), .AW(AW)) u_buf (
    .clk(clk), .rst(rst), .we_i(acc), .waddr_i(AW'(col_q)), .wdata_i(wentry),
    .raddr_i(AW'(j_d)), .rdata_o(rd_buf)
  );

  always_comb begin
    acc = data_in_0_valid && state_q == FILL;
    ohs = vld_q && data_out_0_ready;
    last_n = n_q == NW'(KW - 1);
    last_j = j_q == CW'(W - 1);
    last_m = m_q == MW'(KH - 1);
    load = acc && col_q == CW'(W - 1);
    done = ohs && last_n && last_j && last_m;
    step = ohs && !done;
    state_d = load ? EMIT : done ? FILL : state_q;
    col_d = load ? '0 : acc ? col_q + 1'b1 : col_q;
    n_d = (load || done || (step && last_n)) ? '0 : step ? n_q + 1'b1 : n_q;
    j_d = (load || done || (step && last_n && last_j)) ? '0 : (step && last_n) ? j_q + 1'b1 : j_q;
    m_d = (load || done) ? '0 : (step && last_n && last_j) ? m_q + 1'b1 : m_q;
    row_d = done ? (row_q == RW'(DATA_IN_0_HEIGHT - 1) ? '0 : row_q + 1'b1) : row_q;
    vld_d = load ? 1'b1 : done ? 1'b0 : vld_q;
    wentry = '{value: VAL_MAX_W'(data_in_0), index: IDX_MAX_W'(data_in_1)};
    // forward the entry being written so a single-entry row can emit immediately
    rd = (acc && AW'(j_d) == AW'(col_q)) ? wentry : rd_buf;
    out_d = (load || step) ?
      (rd.index == IDX_MAX_W'(int'(m_d) * KW + int'(n_d)) ? rd.value[DW-1:0] : '0) : out_q;
  end
  assign unused_val = ^rd.value;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      col_q <= '0;
      j_q <= '0;
      n_q <= '0;
      m_q <= '0;
      row_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      j_q <= j_d;
      n_q <= n_d;
      m_q <= m_d;
      row_q <= row_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign data_in_0_ready = state_q == FILL;
  assign data_out_0 = out_q;
  assign data_out_0_valid = vld_q;

`ifdef MAX_UNPOOL2D_IDX_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (acc && int'(data_in_1) >= KW * KH) err_q <= 1'b1;
  end
  assign idx_err = err_q;
`endif
endmodule
